// File: rtl/bcd_pkg.sv
// Shared types, digit constants and arithmetic helpers for the signed-BCD to binary converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned DIGIT_MAX = 9;
    localparam int unsigned MUL_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by ten using only shifts and an add.
    function automatic logic [MUL_W-1:0] mul10(input logic [MUL_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal step: acc*10 + digit, saturated to the binary magnitude range, with error flags.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_N = 14
) (
    input  logic [BIN_N+3:0]   acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [BIN_N+3:0]   acc_c_o,
    output logic               err_digit_c_o,
    output logic               err_of_c_o
);

    localparam int unsigned ACC_W = BIN_N + 4;
    localparam logic [ACC_W-1:0] SAT = {4'b0000, {BIN_N{1'b1}}};

    logic [ACC_W-1:0] sum;

    // Clamping at 2^BIN_N-1 keeps acc*10+15 within ACC_W bits on every step.
    always_comb begin
        sum           = ACC_W'(mul10(MUL_W'(acc_i))) + ACC_W'(digit_i);
        err_digit_c_o = (digit_i > DIGIT_W'(DIGIT_MAX));
        err_of_c_o    = (sum > SAT);
        acc_c_o       = err_of_c_o ? SAT : sum;
    end

endmodule

// File: rtl/bcd2bin.sv
// Iterative signed-BCD to binary converter, one digit per clock, MSD first, start/ready/done_tick handshake.
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int unsigned BCD_N = 4,
    parameter int unsigned BIN_N = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sign_in,
    input  logic [DIGIT_W*BCD_N-1:0] bcd,
    output logic                     ready,
    output logic                     done_tick,
    output logic [BIN_N-1:0]         bin,
    output logic                     sign,
    output logic                     e_digit,
    output logic                     e_of
);

    localparam int unsigned BCD_W = DIGIT_W * BCD_N;
    localparam int unsigned ACC_W = BIN_N + 4;
    localparam int unsigned CNT_W = (BCD_N > 1) ? $clog2(BCD_N) : 1;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   sreg_q, sreg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               sign_lat_q, sign_lat_d;
    logic               err_d_q, err_d_d;
    logic               err_o_q, err_o_d;
    logic [BIN_N-1:0]   bin_q, bin_d;
    logic               sign_q, sign_d;
    logic               e_digit_q, e_digit_d;
    logic               e_of_q, e_of_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [ACC_W-1:0]   mac_acc;
    logic               mac_err_digit;
    logic               mac_err_of;

    bcd_digit_mac #(
        .BIN_N (BIN_N)
    ) u_mac (
        .acc_i         (acc_q),
        .digit_i       (sreg_q[BCD_W-1 -: DIGIT_W]),
        .acc_c_o       (mac_acc),
        .err_digit_c_o (mac_err_digit),
        .err_of_c_o    (mac_err_of)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        acc_d      = acc_q;
        n_d        = n_q;
        sign_lat_d = sign_lat_q;
        err_d_d    = err_d_q;
        err_o_d    = err_o_q;
        bin_d      = bin_q;
        sign_d     = sign_q;
        e_digit_d  = e_digit_q;
        e_of_d     = e_of_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d     = bcd;
                    sign_lat_d = sign_in;
                    acc_d      = '0;
                    err_d_d    = 1'b0;
                    err_o_d    = 1'b0;
                    n_d        = CNT_W'(BCD_N - 1);
                    state_d    = ST_OP;
                end
            end
            ST_OP: begin
                acc_d   = mac_acc;
                sreg_d  = sreg_q << DIGIT_W;
                err_d_d = err_d_q | mac_err_digit;
                err_o_d = err_o_q | mac_err_of;
                if (n_q == '0) begin
                    // Results are published from the final step so they land with done.
                    state_d   = ST_DONE;
                    bin_d     = mac_acc[BIN_N-1:0];
                    sign_d    = sign_lat_q & (mac_acc != '0);
                    e_digit_d = err_d_q | mac_err_digit;
                    e_of_d    = err_o_q | mac_err_of;
                end else begin
                    n_d = n_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // All state and outputs; reset aborts any conversion without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            acc_q      <= '0;
            n_q        <= '0;
            sign_lat_q <= 1'b0;
            err_d_q    <= 1'b0;
            err_o_q    <= 1'b0;
            bin_q      <= '0;
            sign_q     <= 1'b0;
            e_digit_q  <= 1'b0;
            e_of_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            sign_lat_q <= sign_lat_d;
            err_d_q    <= err_d_d;
            err_o_q    <= err_o_d;
            bin_q      <= bin_d;
            sign_q     <= sign_d;
            e_digit_q  <= e_digit_d;
            e_of_q     <= e_of_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready     = ready_q;
    assign done_tick = done_q;
    assign bin       = bin_q;
    assign sign      = sign_q;
    assign e_digit   = e_digit_q;
    assign e_of      = e_of_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench: a 14-bit and a 10-bit converter driven in lockstep against a decimal reference model.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign_in;
    logic [15:0] bcd;

    logic        rdy_a, done_a, sign_a, ed_a, eo_a;
    logic [13:0] bin_a;
    logic        rdy_b, done_b, sign_b, ed_b, eo_b;
    logic [9:0]  bin_b;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    bcd2bin #(.BCD_N(4), .BIN_N(14)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .sign_in(sign_in), .bcd(bcd),
        .ready(rdy_a), .done_tick(done_a), .bin(bin_a), .sign(sign_a),
        .e_digit(ed_a), .e_of(eo_a)
    );

    bcd2bin #(.BCD_N(4), .BIN_N(10)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .sign_in(sign_in), .bcd(bcd),
        .ready(rdy_b), .done_tick(done_b), .bin(bin_b), .sign(sign_b),
        .e_digit(ed_b), .e_of(eo_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: value = sum of digit*10^k, saturating at 2^w-1 after each digit.
    task automatic ref_conv(input logic [15:0] b, input logic s, input int w,
                            output int unsigned v, output logic so, output logic ed, output logic eo);
        int unsigned lim;
        int unsigned d;
        lim = (32'd1 << w) - 1;
        v = 0; ed = 1'b0; eo = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = (32'(b) >> (4 * i)) & 32'hF;
            if (d > 9) ed = 1'b1;
            v = v * 10 + d;
            if (v > lim) begin
                eo = 1'b1;
                v  = lim;
            end
        end
        so = s && (v != 0);
    endtask

    task automatic check_results(input string tag, input logic [15:0] b, input logic s);
        int unsigned v;
        logic so, ed, eo;
        ref_conv(b, s, 14, v, so, ed, eo);
        chk({tag, "_bin14"}, 32'(bin_a), v);
        chk({tag, "_sign14"}, 32'(sign_a), 32'(so));
        chk({tag, "_edig14"}, 32'(ed_a), 32'(ed));
        chk({tag, "_eof14"}, 32'(eo_a), 32'(eo));
        ref_conv(b, s, 10, v, so, ed, eo);
        chk({tag, "_bin10"}, 32'(bin_b), v);
        chk({tag, "_sign10"}, 32'(sign_b), 32'(so));
        chk({tag, "_edig10"}, 32'(ed_b), 32'(ed));
        chk({tag, "_eof10"}, 32'(eo_b), 32'(eo));
    endtask

    // One handshake: start at edge 0, expect done in cycle 5 and ready again in cycle 6.
    task automatic convert(input string tag, input logic [15:0] b, input logic s);
        int cyc;
        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(rdy_a & rdy_b), 32'd1);
        start = 1'b1; bcd = b; sign_in = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; bcd = 16'hFFFF; sign_in = ~s;
        cyc = 1;
        while (done_a !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'd5);
        chk({tag, "_done_both"}, 32'(done_a & done_b), 32'd1);
        check_results(tag, b, s);
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_a | done_b), 32'd0);
        chk({tag, "_ready_post"}, 32'(rdy_a & rdy_b), 32'd1);
    endtask

    typedef struct { logic [15:0] b; logic s; } req_t;

    initial begin
        req_t q[$];
        req_t r;
        int   last_done;
        int   seen;
        logic [15:0] rb;

        reset = 1'b0; start = 1'b0; sign_in = 1'b0; bcd = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_ready", 32'(rdy_a & rdy_b), 32'd1);
        chk("rst_done", 32'(done_a | done_b), 32'd0);
        chk("rst_bin", 32'(bin_a) | 32'(bin_b), 32'd0);
        chk("rst_flags", 32'({sign_a, ed_a, eo_a, sign_b, ed_b, eo_b}), 32'd0);

        // Directed cases including digit errors, overflow edge and negative zero.
        convert("c1234", 16'h1234, 1'b0);
        convert("c9999n", 16'h9999, 1'b1);
        convert("c0000n", 16'h0000, 1'b1);
        convert("c12A4", 16'h12A4, 1'b0);
        convert("c0001", 16'h0001, 1'b0);
        convert("c1024", 16'h1024, 1'b1);
        convert("c1023", 16'h1023, 1'b0);
        convert("cFFFF", 16'hFFFF, 1'b1);

        // Reset mid-conversion aborts silently.
        @(negedge clk);
        start = 1'b1; bcd = 16'h0042; sign_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_ready", 32'(rdy_a & rdy_b), 32'd1);
        chk("abort_bin", 32'(bin_a) | 32'(bin_b), 32'd0);
        chk("abort_flags", 32'({sign_a, ed_a, eo_a, sign_b, ed_b, eo_b}), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_a === 1'b1 || done_b === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        convert("c0042", 16'h0042, 1'b0);

        // Random single conversions, mostly valid digits with occasional bad ones.
        for (int i = 0; i < 20; i++) begin
            rb = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 4; k++)
                    if (rb[4*k +: 4] > 4'd9) rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            convert("rnd", rb, 1'($urandom_range(0, 1)));
        end

        // Start held high with bcd changing every cycle: back-to-back conversions.
        last_done = -1;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 62; cyc++) begin
            if (done_a === 1'b1) begin
                if (q.size() == 0) begin
                    chk("b2b_queue_empty", 32'd1, 32'd0);
                end else begin
                    r = q.pop_front();
                    check_results("b2b", r.b, r.s);
                end
                if (last_done >= 0) chk("b2b_period", 32'(cyc - last_done), 32'd6);
                last_done = cyc;
                seen++;
            end
            bcd = 16'($urandom_range(0, 65535));
            sign_in = 1'($urandom_range(0, 1));
            if (rdy_a === 1'b1) q.push_back('{b: bcd, s: sign_in});
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_count", 32'(seen >= 9), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
